// File: rtl/bus_pkg.sv
// Shared slave-bus definitions: handshake FSM states, BUS_mode encodings,
// timer register offsets and the CTRL register layout.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_W_ACK    = 2'd1,
    ST_R_VAL    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } bus_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_PRESC  = 8'h10;

  typedef struct packed {
    logic ie;
    logic auto_rld;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/bus_slave_if.sv
// Slave-side handshake for the shared valid/ready bus plus window decode.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   BUS_addr/wdata/mode/valid  master request
//   BUS_rready                 master accepts read data
//   BUS_wready, BUS_rvalid     handshake outputs (decoded from state)
//   BUS_rdata                  read data snapshot, 0 while rvalid low
//   wr_en, rd_en               one-cycle strobes into the register core
//   offset, wdata              word-aligned offset and write data
//   rdata_in                   register core read mux, latched on rd_en
module bus_slave_if
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  input  logic        BUS_rready,
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  output logic [31:0] BUS_rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic [7:0]  offset,
  output logic [31:0] wdata,
  input  logic [31:0] rdata_in
);

  bus_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sel, req;
  logic        unused_addr_lsb;

  assign sel    = (BUS_addr[31:8] == BASE_ADDR[31:8]);
  // Requests are only taken in IDLE, so a held valid is serviced once.
  assign req    = (state_q == ST_IDLE) && BUS_valid && sel;
  assign wr_en  = req && (BUS_mode == MODE_WRITE);
  assign rd_en  = req && (BUS_mode == MODE_READ);
  assign offset = {BUS_addr[7:2], 2'b00};
  assign wdata  = BUS_wdata;
  assign unused_addr_lsb = ^BUS_addr[1:0];

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          state_d = ST_W_ACK;
        end else if (rd_en) begin
          state_d = ST_R_VAL;
          rdata_d = rdata_in;
        end
      end
      ST_W_ACK:    state_d = ST_WAIT_LOW;
      ST_R_VAL:    if (BUS_rready) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!BUS_valid) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Decoded straight from the state flop so reset drops them at once.
  assign BUS_wready = (state_q == ST_W_ACK);
  assign BUS_rvalid = (state_q == ST_R_VAL);
  assign BUS_rdata  = BUS_rvalid ? rdata_q : 32'd0;

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped prescaled down-counter with level interrupt.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   BUS_*             shared slave bus (see bus_slave_if)
//   irq               registered STATUS.flag & CTRL.ie
// Registers: CTRL(en,auto_rld,ie) LOAD COUNT STATUS(flag, W1C) PRESC.
module bus_timer_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  input  logic        BUS_rready,
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  output logic [31:0] BUS_rdata,
  output logic        irq
);

  logic        wr_en, rd_en;
  logic [7:0]  offset;
  logic [31:0] wdata, rdata_in;

  bus_slave_if #(.BASE_ADDR(BASE_ADDR)) u_if (
    .clk        (clk),
    .rst_n      (rst_n),
    .BUS_addr   (BUS_addr),
    .BUS_wdata  (BUS_wdata),
    .BUS_mode   (BUS_mode),
    .BUS_valid  (BUS_valid),
    .BUS_rready (BUS_rready),
    .BUS_wready (BUS_wready),
    .BUS_rvalid (BUS_rvalid),
    .BUS_rdata  (BUS_rdata),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .offset     (offset),
    .wdata      (wdata),
    .rdata_in   (rdata_in)
  );

  ctrl_t              ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               flag_q, flag_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               irq_q, irq_d;
  logic               tick, expire;

  assign tick   = ctrl_q.en && (pcnt_q == presc_q);
  assign expire = tick && (count_q == 32'd0);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    flag_d  = flag_q;
    presc_d = presc_q;
    pcnt_d  = '0;

    if (ctrl_q.en) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);

    if (tick) begin
      if (count_q != 32'd0)  count_d   = count_q - 32'd1;
      else if (ctrl_q.auto_rld) count_d = load_q;
      else                   ctrl_d.en = 1'b0;
    end

    // Bus writes are applied after the tick so they take priority.
    if (wr_en) begin
      case (offset)
        OFF_CTRL: begin
          ctrl_d = ctrl_t'(wdata[2:0]);
          if (wdata[0]) pcnt_d = '0;
        end
        OFF_LOAD:   load_d  = wdata;
        OFF_COUNT:  count_d = wdata;
        OFF_STATUS: if (wdata[0]) flag_d = 1'b0;
        OFF_PRESC:  presc_d = wdata[PRESC_W-1:0];
        default:    ;
      endcase
    end

    // Hardware set wins over a same-cycle W1C.
    if (expire) flag_d = 1'b1;

    irq_d = flag_q & ctrl_q.ie;
  end

  always_comb begin
    rdata_in = 32'd0;
    if (rd_en) begin
      case (offset)
        OFF_CTRL:   rdata_in = {29'd0, ctrl_q};
        OFF_LOAD:   rdata_in = load_q;
        OFF_COUNT:  rdata_in = count_q;
        OFF_STATUS: rdata_in = {31'd0, flag_q};
        OFF_PRESC:  rdata_in = 32'(presc_q);
        default:    rdata_in = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave. Inputs change and outputs are sampled
// on the falling edge; read expectations go through a scoreboard queue.
module tb_bus_timer_slave;

  localparam logic [31:0] A_CTRL   = 32'h1000_0000;
  localparam logic [31:0] A_LOAD   = 32'h1000_0004;
  localparam logic [31:0] A_COUNT  = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;
  localparam logic [31:0] A_PRESC  = 32'h1000_0010;

  logic        clk, rst_n;
  logic [31:0] BUS_addr, BUS_wdata, BUS_rdata;
  logic        BUS_mode, BUS_valid, BUS_rready, BUS_wready, BUS_rvalid, irq;

  int vectors = 0;
  int errs    = 0;
  logic [31:0] exp_q[$];

  bus_timer_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BUS_addr   (BUS_addr),
    .BUS_wdata  (BUS_wdata),
    .BUS_mode   (BUS_mode),
    .BUS_valid  (BUS_valid),
    .BUS_rready (BUS_rready),
    .BUS_wready (BUS_wready),
    .BUS_rvalid (BUS_rvalid),
    .BUS_rdata  (BUS_rdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Occupies exactly 3 cycles: request edge, ack edge, WAIT_LOW->IDLE edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
    BUS_addr = addr; BUS_wdata = data; BUS_mode = 1'b1; BUS_valid = 1'b1;
    @(negedge clk);
    check({tag, "_wready"}, 32'(BUS_wready), 32'd1);
    BUS_valid = 1'b0;
    @(negedge clk);
    check({tag, "_wready_pulse"}, 32'(BUS_wready), 32'd0);
    @(negedge clk);
  endtask

  // Same 3-cycle footprint when hold==0; hold keeps rready low longer.
  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input int hold, input string tag);
    logic [31:0] e;
    int n;
    exp_q.push_back(exp);
    BUS_addr = addr; BUS_mode = 1'b0; BUS_valid = 1'b1; BUS_rready = 1'b0;
    @(negedge clk);
    n = 0;
    while (BUS_rvalid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rvalid"}, 32'(BUS_rvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_rvalid_held"}, 32'(BUS_rvalid), 32'd1);
    end
    if (exp_q.size() == 0) begin
      e = 32'hxxxx_xxxx;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_rdata"}, BUS_rdata, e);
    BUS_rready = 1'b1;
    @(negedge clk);
    check({tag, "_rvalid_drop"}, 32'(BUS_rvalid), 32'd0);
    check({tag, "_rdata_zero"}, BUS_rdata, 32'd0);
    BUS_rready = 1'b0; BUS_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; BUS_addr = '0; BUS_wdata = '0; BUS_mode = 1'b0;
    BUS_valid = 1'b0; BUS_rready = 1'b0;
    idle(2);
    check("rst_wready", 32'(BUS_wready), 32'd0);
    check("rst_rvalid", 32'(BUS_rvalid), 32'd0);
    check("rst_rdata",  BUS_rdata,       32'd0);
    check("rst_irq",    32'(irq),        32'd0);
    rst_n = 1'b1;
    idle(1);

    // Reset read of CTRL, rready withheld for two extra cycles.
    bus_read(A_CTRL, 32'd0, 2, "ctrl_reset");
    bus_read(A_COUNT, 32'd0, 0, "count_reset");

    // Unmapped offset reads 0 and swallows writes; addr[1:0] ignored.
    bus_write(32'h1000_0014, 32'hFFFF_FFFF, "unmapped_wr");
    bus_read(32'h1000_0014, 32'd0, 0, "unmapped_rd");
    bus_write(32'h1000_0006, 32'h0000_00AB, "load_alias_wr");
    bus_read(A_LOAD, 32'h0000_00AB, 0, "load_alias_rd");

    // Outside the window: no response, no register change.
    BUS_addr = 32'h2000_0000; BUS_mode = 1'b0; BUS_valid = 1'b1;
    idle(4);
    check("unsel_rd_rvalid", 32'(BUS_rvalid), 32'd0);
    BUS_addr = 32'h2000_0004; BUS_wdata = 32'h1234_5678; BUS_mode = 1'b1;
    idle(4);
    check("unsel_wr_wready", 32'(BUS_wready), 32'd0);
    BUS_valid = 1'b0;
    idle(1);
    bus_read(A_LOAD, 32'h0000_00AB, 0, "unsel_load");

    // Valid held for 5 cycles on one write: single acknowledge.
    BUS_addr = A_LOAD; BUS_wdata = 32'd3; BUS_mode = 1'b1; BUS_valid = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (BUS_wready === 1'b1) pulses++;
    end
    BUS_valid = 1'b0;
    idle(2);
    check("held_wr_pulses", 32'(pulses), 32'd1);
    bus_read(A_LOAD, 32'd3, 0, "held_wr_load");

    // Auto-reload, LOAD=3, PRESC=0. CTRL written at edge C; flag at C+1,
    // then every 4 edges; COUNT after edge C+k is 3-((k-1) mod 4).
    bus_write(A_PRESC, 32'd0, "presc0");
    bus_write(A_CTRL, 32'h7, "ctrl7");
    check("ar_irq_rise", 32'(irq), 32'd1);
    idle(3);
    bus_read(A_COUNT, 32'd3, 0, "ar_cnt_a"); idle(2);  // sampled C+6
    bus_read(A_COUNT, 32'd2, 0, "ar_cnt_b"); idle(2);  // C+11
    bus_read(A_COUNT, 32'd1, 0, "ar_cnt_c"); idle(2);  // C+16
    bus_read(A_COUNT, 32'd0, 0, "ar_cnt_d"); idle(2);  // C+21
    bus_read(A_COUNT, 32'd3, 0, "ar_cnt_e");           // C+26
    // W1C at C+29 lands on a flag-set edge: flag must survive.
    bus_write(A_STATUS, 32'd1, "w1c_collide");
    bus_read(A_STATUS, 32'd1, 0, "w1c_collide_flag");  // C+32
    // W1C at C+35 clears; next set at C+37, irq back at C+38.
    bus_write(A_STATUS, 32'd1, "w1c_clear");
    check("w1c_irq_low", 32'(irq), 32'd0);
    idle(1);
    check("ar_irq_again", 32'(irq), 32'd1);
    idle(2);
    // COUNT write at C+41 coincides with an expiry tick: write wins.
    bus_write(A_COUNT, 32'd100, "count_collide");
    bus_read(A_COUNT, 32'd98, 0, "count_collide_rd");  // 100 at C+41, 98 by C+43

    // One-shot: COUNT=2, PRESC=1. Flag sets 6 edges after the CTRL edge,
    // irq one edge later, i.e. 5 falling edges after the write returns.
    bus_write(A_CTRL, 32'h0, "stop");
    bus_write(A_STATUS, 32'd1, "os_clear");
    bus_write(A_PRESC, 32'd1, "presc1");
    bus_write(A_COUNT, 32'd2, "os_count");
    check("os_irq_idle", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h5, "os_ctrl");
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("os_irq_delay", 32'(n), 32'd5);
    bus_read(A_CTRL, 32'h4, 0, "os_en_clr");
    bus_read(A_COUNT, 32'd0, 0, "os_cnt0");
    idle(5);
    bus_read(A_COUNT, 32'd0, 0, "os_cnt_held");
    bus_read(A_STATUS, 32'd1, 0, "os_flag");
    bus_read(A_PRESC, 32'd1, 0, "presc_rd");

    // Snapshot stability: counter runs while rready is withheld.
    bus_write(A_COUNT, 32'd50, "snap_cnt");
    bus_write(A_CTRL, 32'h1, "snap_en");
    bus_read(A_COUNT, 32'd49, 3, "snap");  // PRESC=1: tick at CTRL edge+2 -> 49

    // Reset in R_VAL: rvalid drops without waiting for a clock.
    BUS_addr = A_LOAD; BUS_mode = 1'b0; BUS_valid = 1'b1;
    @(negedge clk);
    check("rst_rval_before", 32'(BUS_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rval_drop", 32'(BUS_rvalid), 32'd0);
    check("rst_rval_rdata", BUS_rdata, 32'd0);
    BUS_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(A_CTRL,   32'd0, 0, "post_rst_ctrl");
    bus_read(A_LOAD,   32'd0, 0, "post_rst_load");
    bus_read(A_COUNT,  32'd0, 0, "post_rst_count");
    bus_read(A_STATUS, 32'd0, 0, "post_rst_status");
    bus_read(A_PRESC,  32'd0, 0, "post_rst_presc");
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bus_timer_slave.md
# bus_timer_slave

Memory-mapped timer/counter peripheral on the core's shared slave bus, alongside the RAM slave. It decodes its own address window, answers the bus with the same valid/ready read/write handshake as the RAM slave, and raises a level interrupt when a prescaled down-counter expires. It gives the core its first non-memory target, used for delays and periodic events.

## Interface
- BASE_ADDR, 32'h1000_0000: window base; selected when BUS_addr[31:8] == BASE_ADDR[31:8].
- PRESC_W, 16: prescaler register width.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- BUS_addr  in  32  byte address; offset is BUS_addr[7:0].
- BUS_wdata  in  32  write data.
- BUS_mode  in  1  1 = write, 0 = read.
- BUS_valid  in  1  master request; held until the transfer completes.
- BUS_rready  in  1  master accepts read data.
- BUS_wready  out  1  write accepted; one-cycle pulse.
- BUS_rvalid  out  1  read data valid; held until BUS_rready.
- BUS_rdata  out  32  read data; 0 whenever BUS_rvalid is low.
- irq  out  1  STATUS.flag & CTRL.ie.

## Operation
- Register map, by offset:
  - 0x00 CTRL [0] en, [1] auto-reload, [2] ie.
  - 0x04 LOAD, 32 bit.
  - 0x08 COUNT, 32 bit, read/write.
  - 0x0C STATUS [0] flag: write 1 to clear, write 0 has no effect.
  - 0x10 PRESC, PRESC_W bits, zero-extended on read.
- Unmapped offsets in the window read 0; writes to them are acknowledged and ignored. Address bits [1:0] are ignored.
- Bus FSM states: IDLE, W_ACK, R_VAL, WAIT_LOW.
  - IDLE: on valid & selected & mode=1, perform the register write at this edge, then go to W_ACK. On valid & selected & mode=0, latch read data, then go to R_VAL. An unselected request is ignored and the FSM stays in IDLE.
  - W_ACK: wready=1 for exactly one cycle, then go to WAIT_LOW.
  - R_VAL: rvalid=1 and rdata stable. When rready=1, go to WAIT_LOW.
  - WAIT_LOW: return to IDLE once BUS_valid=0. This prevents a held request from being serviced twice.
- Counter:
  - Prescaler pcnt counts 0..PRESC while en=1. A tick fires when pcnt==PRESC, and pcnt then wraps to 0. PRESC=0 gives a tick every cycle.
  - On each tick, if COUNT != 0, COUNT decrements by 1.
  - On a tick with COUNT==0, flag is set:
    - auto-reload=1: COUNT loads LOAD.
    - auto-reload=0: en clears and COUNT stays 0.
  - When en=0, pcnt is held at 0 and COUNT is frozen.
- Simultaneous events:
  - A bus write to COUNT beats a tick in the same cycle; the tick's decrement or reload is dropped.
  - A hardware flag set beats a W1C clear in the same cycle.
  - A write to CTRL that sets en resets pcnt to 0.

## Timing
- Reset values: all outputs 0, all registers 0, FSM in IDLE, pcnt 0.
- Write latency:
  - Cycle 0: request sampled and register updated at the edge.
  - Cycle 1: wready high.
  - The new register value is visible to the counter from cycle 1.
- Read latency:
  - Cycle 0: request sampled.
  - Cycle 1 onward: rvalid high until the cycle after rready is sampled high.
  - rdata is a snapshot taken at cycle 0; later counter updates do not change it.
- The minimum back-to-back transfer is 3 cycles, because valid must drop for one cycle.
- irq is registered and follows the flag one cycle after it sets.
- Reset asserted mid-transaction returns to IDLE immediately and drops wready/rvalid.
- COUNT arithmetic is unsigned 32-bit and never underflows.
- With auto-reload, the expiry period is (LOAD+1)·(PRESC+1) cycles.

## Structure
- Shared package bus_pkg holds:
  - the bus FSM state enum;
  - the BUS_mode constants MODE_READ / MODE_WRITE;
  - the register offset constants.
- bus_pkg is reused by the RAM slave and future slaves.
- One sub-module, bus_slave_if, contains the handshake FSM and address select. It exposes wr_en, rd_en, offset, wdata and rdata_in to the timer core.

## Test plan
- Reset then read CTRL: rdata=0; rvalid is high on cycle 1 and stays high until rready, then drops.
- Write LOAD=3, PRESC=0, CTRL=0x7 (en, auto-reload, ie): flag sets and irq rises every 4 cycles; COUNT sequence 3,2,1,0,3; W1C to STATUS drops irq.
- CTRL=0x1 (one-shot), COUNT=2, PRESC=1: flag sets 6 cycles after en; en reads 0 afterwards; COUNT is held at 0.
- Write COUNT=100 in the same cycle as an expiry tick: COUNT reads 100 and no reload occurs. W1C in the same cycle as a flag set: flag stays 1.
- Hold valid high for 5 cycles on one write: exactly one wready pulse and one register update. A request to addr 0x2000_0000: no response.
- Assert rst_n=0 during R_VAL: rvalid drops asynchronously and all registers read 0 afterwards.
